ext_obi_master_arbiter: RTL and testbench

// - Round-robin arbiter: NUM_MASTERS external OBI masters (external CPU subsystem instr/data/DMA ports) onto the one OBI master port into x_heep_system ext_xbar_master_req_i.
// - Tracks up to MAX_OUTSTANDING in-flight transactions in an ID FIFO; routes each rvalid/rdata back to the master that issued it.
// - Per-master isolate inputs fence a master from new grants before its subsystem is reset or power-gated.
// - Per-master idle flags tell the power controller when the fence has fully drained.

---
 rtl/ext_obi_master_arbiter_if.sv | 27 ++
 rtl/ext_obi_master_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ext_obi_master_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_obi_master_arbiter_if.sv
// OBI bus bundle carrying N parallel lanes of request/response signals.
//   req/we/be/addr/wdata : request fields, driven by the bus master
//   gnt/rvalid/rdata     : response fields, driven by the bus slave
// modport master : request side (drives the request fields)
// modport slave  : response side (drives gnt/rvalid/rdata)
interface ext_obi_master_arbiter_if #(
  parameter int unsigned N = 1
);
  logic [N-1:0]       req;
  logic [N-1:0]       we;
  logic [N-1:0][3:0]  be;
  logic [N-1:0][31:0] addr;
  logic [N-1:0][31:0] wdata;
  logic [N-1:0]       gnt;
  logic [N-1:0]       rvalid;
  logic [N-1:0][31:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ext_obi_master_arbiter.sv
// Round-robin arbiter from NUM_MASTERS external OBI masters onto one OBI master port.
// An ID FIFO records the issuer of every granted transaction so each rvalid/rdata is
// routed back to the master that issued it.
//   clk_i, rst_ni        : clock, async active-low reset
//   masters_if (slave)   : NUM_MASTERS lanes from the external masters
//   slave_if (master)    : single lane towards the x_heep ext_xbar master port
//   isolate_i            : per master, blocks new grants (a locked request still completes)
//   master_idle_o        : per master, nothing outstanding and no locked request
//   outstanding_o        : total granted-but-unanswered transactions
//   unexpected_rvalid_o  : sticky, rvalid seen while no transaction was outstanding
module ext_obi_master_arbiter #(
  parameter int unsigned NUM_MASTERS     = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  ext_obi_master_arbiter_if.slave                masters_if,
  ext_obi_master_arbiter_if.master               slave_if,
  input  logic [NUM_MASTERS-1:0]                 isolate_i,
  output logic [NUM_MASTERS-1:0]                 master_idle_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   unexpected_rvalid_o
);

  localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                                state_q, state_d;
  logic [IdxW-1:0]                       rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]                       sel_q, sel_d;
  logic [MAX_OUTSTANDING-1:0][IdxW-1:0]  fifo_q, fifo_d;
  logic [PtrW-1:0]                       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]                       count_q, count_d;
  logic [NUM_MASTERS-1:0][CntW-1:0]      cnt_q, cnt_d;
  logic                                  unexp_q, unexp_d;

  logic [NUM_MASTERS-1:0] eligible;
  logic                   fifo_full, fifo_empty;
  logic                   found, active, hs, pop;
  logic [IdxW-1:0]        pick, sel, head;
  int unsigned            idx;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (32'(p) == MAX_OUTSTANDING - 1) return '0;
    return p + 1'b1;
  endfunction

  // Full is taken from registered occupancy, so a same-cycle pop does not unblock it.
  assign fifo_full  = (32'(count_q) == MAX_OUTSTANDING);
  assign fifo_empty = (count_q == '0);
  assign eligible   = masters_if.req & ~isolate_i & {NUM_MASTERS{~fifo_full}};
  assign head       = fifo_q[rd_ptr_q];

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_MASTERS;
      if (!found && eligible[IdxW'(idx)]) begin
        found = 1'b1;
        pick  = IdxW'(idx);
      end
    end
  end

  // A locked master keeps the port regardless of isolate/full: OBI forbids retracting req.
  // Reset gates the combinational paths so the port is quiet while rst_ni is low.
  assign sel    = (state_q == StLocked) ? sel_q : pick;
  assign active = rst_ni & ((state_q == StLocked) | found);
  assign hs     = active & slave_if.gnt[0];
  assign pop    = rst_ni & slave_if.rvalid[0] & ~fifo_empty;

  assign slave_if.req   = active;
  assign slave_if.we    = active & masters_if.we[sel];
  assign slave_if.be    = active ? masters_if.be[sel]    : '0;
  assign slave_if.addr  = active ? masters_if.addr[sel]  : '0;
  assign slave_if.wdata = active ? masters_if.wdata[sel] : '0;

  always_comb begin
    masters_if.gnt    = '0;
    masters_if.rvalid = '0;
    masters_if.rdata  = '0;
    if (active) masters_if.gnt[sel] = slave_if.gnt[0];
    if (pop) begin
      masters_if.rvalid[head] = 1'b1;
      masters_if.rdata[head]  = slave_if.rdata[0];
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cnt_d    = cnt_q;
    unexp_d  = unexp_q | (slave_if.rvalid[0] & fifo_empty);

    unique case (state_q)
      StIdle: begin
        if (active && !slave_if.gnt[0]) begin
          state_d = StLocked;
          sel_d   = sel;
        end
      end
      StLocked: begin
        if (slave_if.gnt[0]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (hs) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
      rr_ptr_d         = (32'(sel) == NUM_MASTERS - 1) ? '0 : sel + 1'b1;
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

    count_d = count_q + CntW'(hs) - CntW'(pop);
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (hs && sel == IdxW'(i))   cnt_d[i] = cnt_d[i] + 1'b1;
      if (pop && head == IdxW'(i)) cnt_d[i] = cnt_d[i] - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cnt_q    <= '0;
      unexp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
      unexp_q  <= unexp_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      master_idle_o[i] = (cnt_q[i] == '0) && !(state_q == StLocked && sel_q == IdxW'(i));
    end
  end

  assign outstanding_o       = count_q;
  assign unexpected_rvalid_o = unexp_q;

endmodule

// File: tb/tb_ext_obi_master_arbiter.sv
module tb_ext_obi_master_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] isolate;
  logic [1:0] idle;
  logic [2:0] outstanding;
  logic       unexp;

  int errors = 0;
  int checks = 0;

  ext_obi_master_arbiter_if #(.N(2)) mst_if ();
  ext_obi_master_arbiter_if #(.N(1)) slv_if ();

  ext_obi_master_arbiter #(
    .NUM_MASTERS    (2),
    .MAX_OUTSTANDING(4)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .masters_if         (mst_if),
    .slave_if           (slv_if),
    .isolate_i          (isolate),
    .master_idle_o      (idle),
    .outstanding_o      (outstanding),
    .unexpected_rvalid_o(unexp)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h2000_0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_s(input logic gnt, input logic rvalid, input logic [31:0] rdata);
    slv_if.gnt[0]    = gnt;
    slv_if.rvalid[0] = rvalid;
    slv_if.rdata[0]  = rdata;
  endtask

  initial begin
    mst_if.req      = 2'b00;
    mst_if.we       = 2'b00;
    mst_if.be       = '1;
    mst_if.addr[0]  = A0;
    mst_if.addr[1]  = A1;
    mst_if.wdata[0] = 32'h0000_00a0;
    mst_if.wdata[1] = 32'h0000_00a1;
    isolate         = 2'b00;
    drive_s(1'b0, 1'b0, 32'h0);
    #2;
    // Reset state
    check("rst_slv_req", slv_if.req, 1'b0);
    check("rst_m_gnt", mst_if.gnt, 2'b00);
    check("rst_m_rvalid", mst_if.rvalid, 2'b00);
    check("rst_idle", idle, 2'b11);
    check("rst_outstanding", outstanding, 3'd0);
    check("rst_unexp", unexp, 1'b0);
    tick();
    rst_n = 1'b1;

    // Round robin with both masters requesting, 1-cycle response
    mst_if.req = 2'b11;
    drive_s(1'b1, 1'b0, 32'h0);
    #1;
    check("rr1_req", slv_if.req, 1'b1);
    check("rr1_addr", slv_if.addr, A0);
    check("rr1_gnt", mst_if.gnt, 2'b01);
    tick();
    drive_s(1'b1, 1'b1, 32'haaaa_0000);
    #1;
    check("rr2_addr", slv_if.addr, A1);
    check("rr2_gnt", mst_if.gnt, 2'b10);
    check("rr2_rvalid", mst_if.rvalid, 2'b01);
    check("rr2_rdata0", mst_if.rdata[0], 32'haaaa_0000);
    tick();
    drive_s(1'b1, 1'b1, 32'haaaa_0001);
    #1;
    check("rr3_addr", slv_if.addr, A0);
    check("rr3_gnt", mst_if.gnt, 2'b01);
    check("rr3_rvalid", mst_if.rvalid, 2'b10);
    check("rr3_rdata1", mst_if.rdata[1], 32'haaaa_0001);
    check("rr3_outstanding", outstanding, 3'd1);
    tick();
    mst_if.req = 2'b00;
    drive_s(1'b0, 1'b1, 32'haaaa_0002);
    #1;
    check("rr4_rvalid", mst_if.rvalid, 2'b01);
    check("rr4_rdata0", mst_if.rdata[0], 32'haaaa_0002);
    check("rr4_req", slv_if.req, 1'b0);
    tick();
    drive_s(1'b0, 1'b0, 32'h0);
    #1;
    check("rr_end_outstanding", outstanding, 3'd0);
    check("rr_end_idle", idle, 2'b11);

    // Locked request survives isolate; no further grants once isolated
    mst_if.req = 2'b10;
    #1;
    check("lk1_req", slv_if.req, 1'b1);
    check("lk1_addr", slv_if.addr, A1);
    check("lk1_gnt", mst_if.gnt, 2'b00);
    tick();
    isolate = 2'b10;
    #1;
    check("lk2_req", slv_if.req, 1'b1);
    check("lk2_addr", slv_if.addr, A1);
    check("lk2_idle", idle, 2'b01);
    tick();
    check("lk3_req", slv_if.req, 1'b1);
    check("lk3_addr", slv_if.addr, A1);
    tick();
    drive_s(1'b1, 1'b0, 32'h0);
    #1;
    check("lk4_gnt", mst_if.gnt, 2'b10);
    tick();
    check("lk5_req", slv_if.req, 1'b0);
    check("lk5_gnt", mst_if.gnt, 2'b00);
    check("lk5_idle", idle, 2'b01);
    tick();
    mst_if.req = 2'b00;
    drive_s(1'b0, 1'b1, 32'hbbbb_0003);
    #1;
    check("lk6_rvalid", mst_if.rvalid, 2'b10);
    check("lk6_rdata1", mst_if.rdata[1], 32'hbbbb_0003);
    tick();
    drive_s(1'b0, 1'b0, 32'h0);
    isolate = 2'b00;
    #1;
    check("lk_end_idle", idle, 2'b11);

    // Fill the ID FIFO: full blocks arbitration, a same-cycle pop does not unblock it
    mst_if.req = 2'b01;
    drive_s(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("fill_gnt", mst_if.gnt, 2'b01);
      tick();
    end
    check("full_outstanding", outstanding, 3'd4);
    check("full_req", slv_if.req, 1'b0);
    check("full_gnt", mst_if.gnt, 2'b00);
    drive_s(1'b1, 1'b1, 32'hcccc_0004);
    #1;
    check("full_pop_rvalid", mst_if.rvalid, 2'b01);
    check("full_pop_rdata0", mst_if.rdata[0], 32'hcccc_0004);
    check("full_pop_req", slv_if.req, 1'b0);
    tick();
    drive_s(1'b1, 1'b0, 32'h0);
    #1;
    check("resume_outstanding", outstanding, 3'd3);
    check("resume_req", slv_if.req, 1'b1);
    check("resume_gnt", mst_if.gnt, 2'b01);
    tick();
    mst_if.req = 2'b00;
    drive_s(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    drive_s(1'b0, 1'b0, 32'h0);
    #1;
    check("drain_outstanding", outstanding, 3'd0);
    check("drain_idle", idle, 2'b11);

    // Push and pop in one cycle at occupancy 2, different masters
    mst_if.req = 2'b11;
    drive_s(1'b1, 1'b0, 32'h0);
    #1;
    check("pp_first_gnt", mst_if.gnt, 2'b10);
    tick();
    tick();
    mst_if.req = 2'b01;
    drive_s(1'b1, 1'b1, 32'hdddd_0005);
    #1;
    check("pp_outstanding_before", outstanding, 3'd2);
    check("pp_rvalid", mst_if.rvalid, 2'b10);
    check("pp_rdata1", mst_if.rdata[1], 32'hdddd_0005);
    check("pp_gnt", mst_if.gnt, 2'b01);
    tick();
    mst_if.req = 2'b00;
    drive_s(1'b0, 1'b0, 32'h0);
    #1;
    check("pp_outstanding_after", outstanding, 3'd2);
    check("pp_idle", idle, 2'b10);
    drive_s(1'b0, 1'b1, 32'h0);
    tick();
    tick();
    drive_s(1'b0, 1'b0, 32'h0);
    #1;
    check("pp_drain_outstanding", outstanding, 3'd0);

    // rvalid with empty FIFO
    drive_s(1'b0, 1'b1, 32'heeee_0006);
    #1;
    check("ux_rvalid", mst_if.rvalid, 2'b00);
    check("ux_before", unexp, 1'b0);
    tick();
    drive_s(1'b0, 1'b0, 32'h0);
    check("ux_set", unexp, 1'b1);
    tick();
    tick();
    check("ux_sticky", unexp, 1'b1);

    // Asynchronous reset with 3 outstanding and a locked request
    mst_if.req = 2'b01;
    drive_s(1'b1, 1'b0, 32'h0);
    tick();
    tick();
    tick();
    drive_s(1'b0, 1'b0, 32'h0);
    tick();
    #1;
    check("pre_rst_outstanding", outstanding, 3'd3);
    check("pre_rst_idle", idle, 2'b10);
    rst_n = 1'b0;
    #1;
    check("arst_outstanding", outstanding, 3'd0);
    check("arst_idle", idle, 2'b11);
    check("arst_unexp", unexp, 1'b0);
    check("arst_req", slv_if.req, 1'b0);
    check("arst_gnt", mst_if.gnt, 2'b00);
    mst_if.req = 2'b00;
    tick();
    rst_n = 1'b1;
    drive_s(1'b0, 1'b1, 32'hffff_0007);
    #1;
    check("post_rst_rvalid", mst_if.rvalid, 2'b00);
    tick();
    drive_s(1'b0, 1'b0, 32'h0);
    check("post_rst_unexp", unexp, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
